// File: rtl/ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ctrl_pkg
// Description : Constants shared by the datapath and the multicycle controller.
// Revision    : 1.0 - initial release
//==============================================================================
package ctrl_pkg;

    localparam logic [3:0] c_alu_add   = 4'd0;
    localparam logic [3:0] c_alu_sub   = 4'd1;
    localparam logic [3:0] c_alu_sll   = 4'd2;
    localparam logic [3:0] c_alu_slt   = 4'd3;
    localparam logic [3:0] c_alu_sltu  = 4'd4;
    localparam logic [3:0] c_alu_xor   = 4'd5;
    localparam logic [3:0] c_alu_srl   = 4'd6;
    localparam logic [3:0] c_alu_sra   = 4'd7;
    localparam logic [3:0] c_alu_or    = 4'd8;
    localparam logic [3:0] c_alu_and   = 4'd9;
    localparam logic [3:0] c_alu_passb = 4'd10;

    localparam logic [2:0] c_br_none = 3'd0;
    localparam logic [2:0] c_br_beq  = 3'd1;
    localparam logic [2:0] c_br_bne  = 3'd2;
    localparam logic [2:0] c_br_blt  = 3'd3;
    localparam logic [2:0] c_br_bge  = 3'd4;
    localparam logic [2:0] c_br_bltu = 3'd5;
    localparam logic [2:0] c_br_bgeu = 3'd6;
    localparam logic [2:0] c_br_jump = 3'd7;

    localparam logic [1:0] c_wsrc_alu = 2'd0;
    localparam logic [1:0] c_wsrc_mem = 2'd1;
    localparam logic [1:0] c_wsrc_pc4 = 2'd2;

    localparam logic [1:0] c_ls_byte = 2'd0;
    localparam logic [1:0] c_ls_half = 2'd1;
    localparam logic [1:0] c_ls_word = 2'd2;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [31:0] c_instr_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;

    localparam logic [1:0] c_s_exec     = 2'd0;
    localparam logic [1:0] c_s_mem_wait = 2'd1;
    localparam logic [1:0] c_s_halt     = 2'd2;

    typedef struct packed {
        logic       write_en;
        logic [3:0] alu_sel;
        logic       alu_b_sel;
        logic       alu_a_sel;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] load_store_type;
        logic       load_unsigned;
        logic [1:0] write_src_sel;
        logic [2:0] branch_type;
        logic       stay;
    } ctrl_word_t;

    localparam logic [17:0] c_nop_word = 18'h00001;

    // alt selects SUB/SRA; it is only meaningful for funct3 000 and 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] r_sel;
        case (funct3)
            3'b000:  r_sel = alt ? c_alu_sub : c_alu_add;
            3'b001:  r_sel = c_alu_sll;
            3'b010:  r_sel = c_alu_slt;
            3'b011:  r_sel = c_alu_sltu;
            3'b100:  r_sel = c_alu_xor;
            3'b101:  r_sel = alt ? c_alu_sra : c_alu_srl;
            3'b110:  r_sel = c_alu_or;
            default: r_sel = c_alu_and;
        endcase
        return r_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_ctrl_if
// Description : Datapath <-> controller bundle: instruction, memory handshake,
//               control word and status.
// Revision    : 1.0 - initial release
//==============================================================================
interface multicycle_ctrl_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic [17:0] ctrl_signals;
    logic        mem_req;
    logic        retire;
    logic        halted;
    logic        error;

    modport master (
        output instruction,
        output mem_ready,
        input  ctrl_signals,
        input  mem_req,
        input  retire,
        input  halted,
        input  error
    );

    modport slave (
        input  instruction,
        input  mem_ready,
        output ctrl_signals,
        output mem_req,
        output retire,
        output halted,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
//==============================================================================
// Module      : ctrl_decode
// Description : Combinational RV32I decoder producing the ungated control word
//               plus memory / illegal / system classification.
// Revision    : 1.0 - initial release
//==============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  wire logic [31:0] i_instruction,
    output ctrl_word_t       o_word,
    output logic             o_is_mem,
    output logic             o_illegal,
    output logic             o_is_sys
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instruction[6:0];
    assign w_funct3 = i_instruction[14:12];
    assign w_funct7 = i_instruction[31:25];

    always_comb begin
        o_word    = '0;
        o_is_mem  = 1'b0;
        o_illegal = 1'b0;
        o_is_sys  = 1'b0;
        case (w_opcode)
            c_op_lui: begin
                o_word.write_en  = 1'b1;
                o_word.alu_sel   = c_alu_passb;
                o_word.alu_b_sel = 1'b1;
            end
            c_op_auipc: begin
                o_word.write_en  = 1'b1;
                o_word.alu_sel   = c_alu_add;
                o_word.alu_a_sel = 1'b1;
                o_word.alu_b_sel = 1'b1;
            end
            c_op_jal, c_op_jalr: begin
                o_word.write_en      = 1'b1;
                o_word.alu_sel       = c_alu_add;
                o_word.alu_a_sel     = (w_opcode == c_op_jal);
                o_word.alu_b_sel     = 1'b1;
                o_word.branch_type   = c_br_jump;
                o_word.write_src_sel = c_wsrc_pc4;
                o_illegal            = (w_opcode == c_op_jalr) && (w_funct3 != 3'b000);
            end
            c_op_branch: begin
                o_word.alu_sel = c_alu_sub;
                case (w_funct3)
                    3'b000:  o_word.branch_type = c_br_beq;
                    3'b001:  o_word.branch_type = c_br_bne;
                    3'b100:  o_word.branch_type = c_br_blt;
                    3'b101:  o_word.branch_type = c_br_bge;
                    3'b110:  o_word.branch_type = c_br_bltu;
                    3'b111:  o_word.branch_type = c_br_bgeu;
                    default: o_illegal = 1'b1;
                endcase
            end
            c_op_load: begin
                o_is_mem             = 1'b1;
                o_word.write_en      = 1'b1;
                o_word.alu_sel       = c_alu_add;
                o_word.alu_b_sel     = 1'b1;
                o_word.mem_read      = 1'b1;
                o_word.write_src_sel = c_wsrc_mem;
                case (w_funct3)
                    3'b000: o_word.load_store_type = c_ls_byte;
                    3'b001: o_word.load_store_type = c_ls_half;
                    3'b010: o_word.load_store_type = c_ls_word;
                    3'b100: begin
                        o_word.load_store_type = c_ls_byte;
                        o_word.load_unsigned   = 1'b1;
                    end
                    3'b101: begin
                        o_word.load_store_type = c_ls_half;
                        o_word.load_unsigned   = 1'b1;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            c_op_store: begin
                o_is_mem               = 1'b1;
                o_word.alu_sel         = c_alu_add;
                o_word.alu_b_sel       = 1'b1;
                o_word.mem_write       = 1'b1;
                o_word.load_store_type = w_funct3[1:0];
                o_illegal              = (w_funct3[2] == 1'b1) || (w_funct3[1:0] == 2'b11);
            end
            c_op_imm: begin
                o_word.write_en  = 1'b1;
                o_word.alu_b_sel = 1'b1;
                o_word.write_src_sel = c_wsrc_alu;
                // Shift immediates carry a funct7-like field; everything else is a plain immediate
                o_word.alu_sel   = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if (w_funct3 == 3'b001)
                    o_illegal = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    o_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
            end
            c_op_reg: begin
                o_word.write_en = 1'b1;
                o_word.alu_sel  = alu_from_funct3(w_funct3, w_funct7[5]);
                if (w_funct7 == 7'b0100000)
                    o_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                else
                    o_illegal = (w_funct7 != 7'b0000000);
            end
            c_op_system: begin
                if ((i_instruction == c_instr_ecall) || (i_instruction == c_instr_ebreak))
                    o_is_sys = 1'b1;
                else
                    o_illegal = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase

        if (o_illegal) begin
            o_word   = '0;
            o_is_mem = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_ctrl
// Description : Control sequencer: decodes instructions and stretches loads and
//               stores over a variable-latency memory, halting on faults.
// Revision    : 1.0 - initial release
//==============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = $clog2(MEM_TIMEOUT + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    multicycle_ctrl_if.slave      bus
);

    ctrl_word_t           w_dec_word;
    logic                 w_is_mem;
    logic                 w_illegal;
    logic                 w_is_sys;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_error;

    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_error_nxt;
    ctrl_word_t           w_ctrl;
    logic                 w_mem_req;
    logic                 w_retire;
    logic                 w_halted;
    logic                 w_error;

    ctrl_decode u_decode (
        .i_instruction (bus.instruction),
        .o_word        (w_dec_word),
        .o_is_mem      (w_is_mem),
        .o_illegal     (w_illegal),
        .o_is_sys      (w_is_sys)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_error_nxt = r_error;
        w_ctrl      = ctrl_word_t'(c_nop_word);
        w_mem_req   = 1'b0;
        w_retire    = 1'b0;
        w_halted    = 1'b0;
        w_error     = 1'b0;

        case (r_state)
            c_s_exec, c_s_mem_wait: begin
                if (w_illegal) begin
                    w_state_nxt = c_s_halt;
                    w_error_nxt = 1'b1;
                end else if (w_is_sys) begin
                    w_state_nxt = c_s_halt;
                    w_error_nxt = 1'b0;
                end else if (!w_is_mem) begin
                    w_ctrl      = w_dec_word;
                    w_retire    = 1'b1;
                    w_state_nxt = c_s_exec;
                end else begin
                    w_mem_req = 1'b1;
                    w_ctrl    = w_dec_word;
                    if (bus.mem_ready) begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_s_exec;
                        w_cnt_nxt   = '0;
                    end else begin
                        // Hold the PC and suppress the register write until the access lands
                        w_ctrl.write_en = 1'b0;
                        w_ctrl.stay     = 1'b1;
                        if (r_state == c_s_exec) begin
                            w_state_nxt = c_s_mem_wait;
                            w_cnt_nxt   = CNT_WIDTH'(1);
                        end else if (r_cnt == CNT_WIDTH'(MEM_TIMEOUT)) begin
                            w_state_nxt = c_s_halt;
                            w_error_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
            end
            c_s_halt: begin
                w_halted = 1'b1;
                w_error  = r_error;
            end
            default: begin
                w_state_nxt = c_s_exec;
                w_cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            w_ctrl    = ctrl_word_t'(c_nop_word);
            w_mem_req = 1'b0;
            w_retire  = 1'b0;
            w_halted  = 1'b0;
            w_error   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_exec;
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_error <= w_error_nxt;
        end
    end

    assign bus.ctrl_signals = w_ctrl;
    assign bus.mem_req      = w_mem_req;
    assign bus.retire       = w_retire;
    assign bus.halted       = w_halted;
    assign bus.error        = w_error;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed, table-driven self-checking bench for multicycle_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 16;

    localparam logic [31:0] c_addi   = 32'h0050_0093;
    localparam logic [31:0] c_lw     = 32'h0040_A103;
    localparam logic [31:0] c_sw     = 32'h0020_A423;
    localparam logic [31:0] c_bad    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_ecall  = 32'h0000_0073;

    typedef struct {
        logic [31:0] instr;
        logic        ready;
        logic [17:0] exp_ctrl;
        logic        exp_req;
        logic        exp_retire;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [17:0] ctrl, input logic req,
                           input logic ret, input logic hlt, input logic err);
        chk({nm, ".ctrl"},   32'(bus_if.ctrl_signals), 32'(ctrl));
        chk({nm, ".req"},    32'(bus_if.mem_req),      32'(req));
        chk({nm, ".retire"}, 32'(bus_if.retire),       32'(ret));
        chk({nm, ".halted"}, 32'(bus_if.halted),       32'(hlt));
        chk({nm, ".error"},  32'(bus_if.error),        32'(err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts mem_req cycles until halted appears (bounded); also flags any retire
    task automatic run_to_halt(output int req_cycles, output int retires, output bit seen);
        req_cycles = 0;
        retires    = 0;
        seen       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.halted) begin
                seen = 1'b1;
                break;
            end
            if (bus_if.mem_req) req_cycles++;
            if (bus_if.retire)  retires++;
            tick();
        end
    endtask

    vec_t vecs[14];

    initial begin
        int req_cycles;
        int retires;
        int we_cycles;
        bit seen;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.instruction = c_addi;
        bus_if.mem_ready   = 1'b0;

        vecs[0]  = '{c_addi,       1'b0, 18'h21000, 1'b0, 1'b1};
        vecs[1]  = '{32'h002081B3, 1'b0, 18'h20000, 1'b0, 1'b1};
        vecs[2]  = '{32'h402081B3, 1'b0, 18'h22000, 1'b0, 1'b1};
        vecs[3]  = '{32'h4030D093, 1'b0, 18'h2F000, 1'b0, 1'b1};
        vecs[4]  = '{32'h123450B7, 1'b0, 18'h35000, 1'b0, 1'b1};
        vecs[5]  = '{32'h00000097, 1'b0, 18'h21800, 1'b0, 1'b1};
        vecs[6]  = '{32'h008000EF, 1'b0, 18'h2182E, 1'b0, 1'b1};
        vecs[7]  = '{32'h000080E7, 1'b0, 18'h2102E, 1'b0, 1'b1};
        vecs[8]  = '{32'h00208463, 1'b0, 18'h02002, 1'b0, 1'b1};
        vecs[9]  = '{32'h0020F463, 1'b0, 18'h0200C, 1'b0, 1'b1};
        vecs[10] = '{32'h0000C083, 1'b1, 18'h21250, 1'b1, 1'b1};
        vecs[11] = '{32'h00009083, 1'b1, 18'h21290, 1'b1, 1'b1};
        vecs[12] = '{32'h00209023, 1'b1, 18'h01480, 1'b1, 1'b1};
        vecs[13] = '{c_addi,       1'b1, 18'h21000, 1'b0, 1'b1};

        // Reset held two cycles, then first instruction executes
        #1;
        chk_out("rst0", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rst1", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_out("addi_first", 18'h21000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        foreach (vecs[i]) begin
            bus_if.instruction = vecs[i].instr;
            bus_if.mem_ready   = vecs[i].ready;
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_req,
                    vecs[i].exp_retire, 1'b0, 1'b0);
            tick();
        end

        // LW with ready on the 3rd cycle
        bus_if.instruction = c_lw;
        bus_if.mem_ready   = 1'b0;
        we_cycles = 0;
        #1;
        chk_out("lw_c1", 18'h01311, 1'b1, 1'b0, 1'b0, 1'b0);
        we_cycles += int'(bus_if.ctrl_signals[17]);
        tick();
        chk_out("lw_c2", 18'h01311, 1'b1, 1'b0, 1'b0, 1'b0);
        we_cycles += int'(bus_if.ctrl_signals[17]);
        tick();
        bus_if.mem_ready = 1'b1;
        #1;
        chk_out("lw_c3", 18'h21310, 1'b1, 1'b1, 1'b0, 1'b0);
        we_cycles += int'(bus_if.ctrl_signals[17]);
        tick();
        bus_if.instruction = c_addi;
        bus_if.mem_ready   = 1'b0;
        #1;
        chk_out("lw_after", 18'h21000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lw_we_cycles", 32'(we_cycles), 32'd1);
        tick();

        // SW completing immediately, then an ALU op proves S_EXEC
        bus_if.instruction = c_sw;
        bus_if.mem_ready   = 1'b1;
        #1;
        chk_out("sw_fast", 18'h01500, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus_if.instruction = c_addi;
        bus_if.mem_ready   = 1'b0;
        #1;
        chk_out("sw_after", 18'h21000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // LW timeout
        bus_if.instruction = c_lw;
        bus_if.mem_ready   = 1'b0;
        #1;
        run_to_halt(req_cycles, retires, seen);
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_req_cycles", 32'(req_cycles), 32'(MEM_TIMEOUT + 1));
        chk("to_retires", 32'(retires), 32'd0);
        chk_out("to_halt", 18'h00001, 1'b0, 1'b0, 1'b1, 1'b1);
        bus_if.mem_ready = 1'b1;
        tick();
        tick();
        chk_out("to_sticky", 18'h00001, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("to_rst", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Illegal instruction
        bus_if.instruction = c_bad;
        #1;
        chk_out("ill_c1", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ill_c2", 18'h00001, 1'b0, 1'b0, 1'b1, 1'b1);
        bus_if.instruction = c_addi;
        do_reset();

        // ECALL halts without error
        bus_if.instruction = c_ecall;
        #1;
        chk_out("ecall_c1", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ecall_c2", 18'h00001, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_if.instruction = c_addi;
        do_reset();

        // Reset aborting a load in its 2nd MEM_WAIT cycle
        bus_if.instruction = c_lw;
        bus_if.mem_ready   = 1'b0;
        #1;
        chk("ab_retire0", 32'(bus_if.retire), 32'd0);
        tick();
        chk("ab_retire1", 32'(bus_if.retire), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk_out("ab_rst", 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_out("ab_exec", 18'h01311, 1'b1, 1'b0, 1'b0, 1'b0);
        // A full-length timeout afterwards shows the counter restarted from zero
        run_to_halt(req_cycles, retires, seen);
        chk("ab_seen", 32'(seen), 32'd1);
        chk("ab_req_cycles", 32'(req_cycles), 32'(MEM_TIMEOUT + 1));
        chk("ab_retires", 32'(retires), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control sequencer for the single-cycle datapath. It decodes the fetched instruction into the 18-bit control word `ctrl_signals`. It also stretches loads and stores over a variable-latency data memory using a req/ready handshake, holding the PC via `stay` until the access completes. Side effects (`write_en`, `mem_write`) are gated so each instruction commits exactly once. Illegal instructions, ECALL/EBREAK and memory timeouts halt the core.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before an error halt.
- CNT_WIDTH, $clog2(MEM_TIMEOUT+1): width of the wait counter.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, synchronous, active-high.
- instruction  in  32: current instruction; stable while `stay`=1.
- mem_ready  in  1: data memory has completed the access in this cycle.
- ctrl_signals  out  18: control word to the datapath.
- mem_req  out  1: load/store access in progress.
- retire  out  1: one-cycle pulse when the instruction completes (`stay`=0).
- halted  out  1: core stopped.
- error  out  1: stop caused by timeout or illegal opcode.

Behaviour:
- Control word packing, MSB first: {write_en[17], alu_sel[16:13], alu_b_sel[12], alu_a_sel[11], mem_write[10], mem_read[9], load_store_type[8:7], load_unsigned[6], write_src_sel[5:4], branch_type[3:1], stay[0]}.
- NOP word is 0x00001: all fields 0 except `stay`=1.
- Reset (`rst`=1 at a clock edge) wins over every other event:
  - State goes to S_EXEC and the counter is cleared.
  - While `rst`=1, outputs are forced: `ctrl_signals`=NOP, `mem_req`=0, `retire`=0, `halted`=0, `error`=0.
- Outputs are combinational from state, instruction and `mem_ready`. Registered state is the FSM plus the wait counter.
- Decode rules:
  - R/I-ALU: `alu_b_sel`=1 for I-type.
  - LUI: ALU_PASSB, `b_sel`=1.
  - AUIPC: ADD, `a_sel`=1, `b_sel`=1.
  - JAL: ADD, `a_sel`=1, `b_sel`=1, branch JUMP, `write_src`=PC4.
  - JALR: as JAL but `a_sel`=0.
  - Branches: SUB, `b_sel`=0, `write_en`=0, branch code from funct3.
  - Loads/stores: ADD, `b_sel`=1.
  - `load_store_type`: 00 byte, 01 half, 10 word.
  - `load_unsigned`=1 for LBU/LHU.
- States:
  - S_EXEC, non-memory instruction: full control word with `stay`=0 and `retire`=1; remain in S_EXEC.
  - S_EXEC, load/store: `mem_req`=1 and `mem_read`/`mem_write` asserted.
    - If `mem_ready`=1: complete in this cycle (`write_en`=1 for loads, `stay`=0, `retire`=1) and remain in S_EXEC.
    - Else: `write_en`=0, `stay`=1, go to S_MEM_WAIT with the counter set to 1.
  - S_MEM_WAIT: same word as S_EXEC; `mem_req`, `mem_read`/`mem_write` held steady.
    - `mem_ready`=1: complete as above, go to S_EXEC.
    - Else, counter==MEM_TIMEOUT: go to S_HALT with `error`=1.
    - Else: increment the counter.
  - S_HALT: `ctrl_signals`=NOP, `mem_req`=0, `halted`=1, `error` held. Exits only on `rst`.
- Halt conditions:
  - Unknown opcode or funct3 (includes funct7 for R-type): S_EXEC drives NOP, next state S_HALT with `error`=1.
  - ECALL/EBREAK: S_HALT with `error`=0.
- `mem_req` never drops before `mem_ready` except on `rst` or timeout. `mem_ready` with `mem_req`=0 is ignored.
- `mem_write` is asserted through the whole handshake. The memory commits the store on the ready cycle only.

Decomposition:
- `ctrl_pkg` holds the shared constants, used by both the datapath and this controller:
  - ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - Branch codes: NONE 0, BEQ 1, BNE 2, BLT 3, BGE 4, BLTU 5, BGEU 6, JUMP 7.
  - Write-source codes: ALU 0, MEM 1, PC4 2.
  - Opcode constants, the state enum and the NOP word.
- Sub-module `ctrl_decode`: purely combinational instruction → {control word, is_mem, illegal, is_sys}. The FSM in `multicycle_ctrl` gates `write_en`, `stay` and `mem_req` on top of it.

Test Plan:
- Apply `rst` 2 cycles with `instruction`=0x00500093, then release → during reset `ctrl_signals`=0x00001 and `retire`=0; first cycle after release `ctrl_signals`=0x21000 and `retire`=1.
- LW 0x0040A103, `mem_ready` rises on the 3rd cycle → 2 cycles of 0x01311 with `mem_req`=1, then 0x21310 with `retire`=1 once; `write_en` high exactly 1 cycle.
- SW 0x0020A423 with `mem_ready`=1 immediately → single cycle 0x01500, `mem_req`=1, `retire`=1, state stays S_EXEC.
- LW with `mem_ready` held 0 → `mem_req` high for MEM_TIMEOUT+1 cycles, then `halted`=1, `error`=1 and `ctrl_signals`=0x00001 until `rst`.
- `instruction`=0xFFFFFFFF → NOP, then `halted`=1 and `error`=1. `instruction`=0x00000073 → `halted`=1, `error`=0.
- Assert `rst` on the 2nd MEM_WAIT cycle of a load → same cycle `mem_req`=0 and `write_en`=0; next cycle state S_EXEC with the counter cleared; no `retire` for the aborted load.
